// File: rtl/subneg_ctrl.sv
// Multi-cycle SUBNEG sequencer: fetch A/B/C, read operands, write mem[B]-mem[A], pick next PC.
// Optional halt-on-branch-to-all-ones is enabled by defining SUBNEG_HALT_EN.
module subneg_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] pc_plus3,
  output logic [WIDTH-1:0] br_target,
  output logic             pc_sel,
  input  logic [WIDTH-1:0] pc_next,
  output logic             busy,
  output logic             halted
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_FA   = 4'd1;
  localparam logic [3:0] S_FB   = 4'd2;
  localparam logic [3:0] S_FC   = 4'd3;
  localparam logic [3:0] S_RA   = 4'd4;
  localparam logic [3:0] S_RB   = 4'd5;
  localparam logic [3:0] S_WB   = 4'd6;
  localparam logic [3:0] S_UPD  = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] a_ptr_q, a_ptr_d;
  logic [WIDTH-1:0] b_ptr_q, b_ptr_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] br_target_q, br_target_d;
  logic             pc_sel_q, pc_sel_d;
  logic [WIDTH-1:0] diff;
  logic             halt_take;

  assign diff = mem_rdata - opa_q;

`ifdef SUBNEG_HALT_EN
  assign halt_take = pc_sel_q && (br_target_q == {WIDTH{1'b1}});
  assign halted    = (state_q == S_HALT);
`else
  assign halt_take = 1'b0;
  assign halted    = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign pc_plus3  = pc_q + WIDTH'(3);
  assign br_target = br_target_q;
  assign pc_sel    = pc_sel_q;

  // Memory-facing outputs depend only on the registered state and pointers.
  always_comb begin
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_FB: mem_addr = pc_q + WIDTH'(1);
      S_FC: mem_addr = pc_q + WIDTH'(2);
      S_RA: mem_addr = a_ptr_q;
      S_RB: mem_addr = b_ptr_q;
      S_WB: begin
        mem_addr  = b_ptr_q;
        mem_we    = 1'b1;
        mem_wdata = diff;
      end
      default: mem_addr = pc_q;
    endcase
  end

  // Each state latches the word requested by the previous state's address.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_ptr_d     = a_ptr_q;
    b_ptr_d     = b_ptr_q;
    opa_d       = opa_q;
    br_target_d = br_target_q;
    pc_sel_d    = pc_sel_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FA;
      S_FA:   state_d = S_FB;
      S_FB: begin
        a_ptr_d = mem_rdata;
        state_d = S_FC;
      end
      S_FC: begin
        b_ptr_d = mem_rdata;
        state_d = S_RA;
      end
      S_RA: begin
        br_target_d = mem_rdata;
        state_d     = S_RB;
      end
      S_RB: begin
        opa_d   = mem_rdata;
        state_d = S_WB;
      end
      S_WB: begin
        pc_sel_d = diff[WIDTH-1];
        state_d  = S_UPD;
      end
      S_UPD: begin
        pc_d    = pc_next;
        state_d = halt_take ? S_HALT : S_FA;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      opa_q       <= '0;
      br_target_q <= '0;
      pc_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_ptr_q     <= a_ptr_d;
      b_ptr_q     <= b_ptr_d;
      opa_q       <= opa_d;
      br_target_q <= br_target_d;
      pc_sel_q    <= pc_sel_d;
    end
  end

endmodule

// File: tb/tb_subneg_ctrl.sv
// Directed bench for subneg_ctrl: memory model plus combinational next-PC mux around the DUT.
module tb_subneg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr, mem_rdata, mem_wdata, pc_plus3, br_target, pc_next;
  logic       mem_we, pc_sel, busy, halted;

  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  logic [7:0] we_addr = 8'h00;
  logic [7:0] we_data = 8'h00;

  always #5 clk = ~clk;

  subneg_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .pc_plus3(pc_plus3), .br_target(br_target), .pc_sel(pc_sel), .pc_next(pc_next),
    .busy(busy), .halted(halted)
  );

  assign pc_next = pc_sel ? br_target : pc_plus3;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we_cnt = 0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_we", {7'd0, mem_we}, 8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    chk("rst_pcsel", {7'd0, pc_sel}, 8'h00);
    chk("rst_brt", br_target, 8'h00);
    chk("rst_pc3", pc_plus3, 8'h03);

    // Non-negative result: 5 - 3 = 2
    load(8'd0, 8'd10); load(8'd1, 8'd11); load(8'd2, 8'd20);
    load(8'd10, 8'd3); load(8'd11, 8'd5);
    go();
    chk("t1_fa_addr", mem_addr, 8'h00);
    chk("t1_fa_busy", {7'd0, busy}, 8'h01);
    repeat (7) tick();
    $display("txn nonneg: we_addr=%0d we_data=%h pc_sel=%0d pc=%h", we_addr, we_data, pc_sel, mem_addr);
    chk("t1_wdata", we_data, 8'h02);
    chk("t1_weaddr", we_addr, 8'd11);
    chk("t1_wecnt", 8'(we_cnt), 8'd1);
    chk("t1_mem11", mem[11], 8'h02);
    chk("t1_pcsel", {7'd0, pc_sel}, 8'h00);
    chk("t1_pc", mem_addr, 8'h03);
    chk("t1_brt", br_target, 8'd20);

    // Negative result: 5 - 7 = 0xFE, branch to 20
    do_reset();
    load(8'd10, 8'd7); load(8'd11, 8'd5);
    go();
    repeat (7) tick();
    $display("txn neg: we_data=%h pc_sel=%0d pc=%h", we_data, pc_sel, mem_addr);
    chk("t2_mem11", mem[11], 8'hFE);
    chk("t2_pcsel", {7'd0, pc_sel}, 8'h01);
    chk("t2_pc", mem_addr, 8'd20);
    chk("t2_wecnt", 8'(we_cnt), 8'd1);

    // Zero result with A == B
    do_reset();
    chk("t3_rst_pcsel", {7'd0, pc_sel}, 8'h00);
    load(8'd0, 8'd11); load(8'd1, 8'd11); load(8'd11, 8'h40);
    go();
    repeat (7) tick();
    $display("txn zero: we_data=%h pc_sel=%0d pc=%h", we_data, pc_sel, mem_addr);
    chk("t3_mem11", mem[11], 8'h00);
    chk("t3_pcsel", {7'd0, pc_sel}, 8'h00);
    chk("t3_pc", mem_addr, 8'h03);

    // Overflow: 0x80 - 0x01 = 0x7F, not negative
    do_reset();
    load(8'd0, 8'd12); load(8'd1, 8'd13); load(8'd12, 8'h01); load(8'd13, 8'h80);
    go();
    repeat (7) tick();
    $display("txn ovf: we_data=%h pc_sel=%0d pc=%h", we_data, pc_sel, mem_addr);
    chk("t4_mem13", mem[13], 8'h7F);
    chk("t4_pcsel", {7'd0, pc_sel}, 8'h00);
    chk("t4_pc", mem_addr, 8'h03);

    // PC wrap: branch to 0xFE, then run the instruction at 0xFE/0xFF/0x00
    do_reset();
    load(8'd0, 8'd10); load(8'd1, 8'd11); load(8'd2, 8'hFE);
    load(8'd10, 8'd7); load(8'd11, 8'd5);
    load(8'hFE, 8'd12); load(8'hFF, 8'd13); load(8'd12, 8'd1); load(8'd13, 8'd5);
    go();
    repeat (7) tick();
    chk("t5_pc", mem_addr, 8'hFE);
    chk("t5_pc3", pc_plus3, 8'h01);
    tick();
    chk("t5_fb_addr", mem_addr, 8'hFF);
    tick();
    chk("t5_fc_addr", mem_addr, 8'h00);
    repeat (5) tick();
    $display("txn wrap: we_data=%h pc_sel=%0d pc=%h", we_data, pc_sel, mem_addr);
    chk("t5_mem13", mem[13], 8'h04);
    chk("t5_pc2", mem_addr, 8'h01);
    chk("t5_wecnt", 8'(we_cnt), 8'd2);

    // Taken branch to all-ones
    do_reset();
    load(8'd0, 8'd10); load(8'd1, 8'd11); load(8'd2, 8'hFF);
    load(8'd10, 8'd7); load(8'd11, 8'd5);
    go();
    repeat (7) tick();
    $display("txn br_ff: pc_sel=%0d halted=%0d busy=%0d addr=%h", pc_sel, halted, busy, mem_addr);
`ifdef SUBNEG_HALT_EN
    chk("t6_halted", {7'd0, halted}, 8'h01);
    chk("t6_busy", {7'd0, busy}, 8'h00);
    chk("t6_pc3", pc_plus3, 8'h02);
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    chk("t6_wecnt", 8'(we_cnt), 8'd1);
    chk("t6_halted2", {7'd0, halted}, 8'h01);
    chk("t6_we", {7'd0, mem_we}, 8'h00);
`else
    chk("t6_halted", {7'd0, halted}, 8'h00);
    chk("t6_busy", {7'd0, busy}, 8'h01);
    chk("t6_addr0", mem_addr, 8'hFF);
    tick();
    chk("t6_addr1", mem_addr, 8'h00);
    tick();
    chk("t6_addr2", mem_addr, 8'h01);
`endif

    // Reset during RB, then re-execute from pc 0
    do_reset();
    load(8'd0, 8'd10); load(8'd1, 8'd11); load(8'd2, 8'd20);
    load(8'd10, 8'd3); load(8'd11, 8'd5);
    go();
    repeat (4) tick();
    chk("t7_rb_addr", mem_addr, 8'd11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("txn midrst: busy=%0d we=%0d addr=%h m11=%h", busy, mem_we, mem_addr, mem[11]);
    chk("t7_we", {7'd0, mem_we}, 8'h00);
    chk("t7_busy", {7'd0, busy}, 8'h00);
    chk("t7_addr", mem_addr, 8'h00);
    chk("t7_pc3", pc_plus3, 8'h03);
    chk("t7_mem11", mem[11], 8'h05);
    chk("t7_wecnt", 8'(we_cnt), 8'd0);
    go();
    repeat (7) tick();
    $display("txn rerun: we_data=%h pc=%h", we_data, mem_addr);
    chk("t7_rerun_mem11", mem[11], 8'h02);
    chk("t7_rerun_pc", mem_addr, 8'h03);
    chk("t7_rerun_wecnt", 8'(we_cnt), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subneg_ctrl.md
# subneg_ctrl

Multi-cycle sequencer for the SUBNEG core. Fetches the three-word instruction (A, B, C) at the program counter and reads the operands mem[A] and mem[B]. Writes mem[B] − mem[A] back to memory and decides the next PC. The next-PC mux sits directly downstream: this block drives that mux's `in1`, `in2` and `sel`, and loads the mux's `out` back into the PC.

## Interface
Parameters:
- `WIDTH`, 8: data word width, address width and PC width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `mem_addr`  out  WIDTH  address for the single-port synchronous memory. Read data appears one cycle later.
- `mem_rdata`  in  WIDTH  memory read data.
- `mem_wdata`  out  WIDTH  write data.
- `mem_we`  out  1  write enable.
- `pc_plus3`  out  WIDTH  pc + 3, modulo 2^WIDTH; connects to mux `in1`.
- `br_target`  out  WIDTH  latched C word; connects to mux `in2`.
- `pc_sel`  out  1  branch-taken flag; connects to mux `sel`.
- `pc_next`  in  WIDTH  mux `out`.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
The FSM has states IDLE, FA, FB, FC, RA, RB, WB, UPD and HALT. Memory-facing outputs are decoded from the registered state and registers only.

- **IDLE:** `mem_addr` = pc, `mem_we` = 0. If `start` = 1, go to FA.
- **FA:** `mem_addr` = pc. Go to FB.
- **FB:** `mem_addr` = pc+1. Latch `a_ptr` ← `mem_rdata`. Go to FC.
- **FC:** `mem_addr` = pc+2. Latch `b_ptr` ← `mem_rdata`. Go to RA.
- **RA:** `mem_addr` = `a_ptr`. Latch `br_target` ← `mem_rdata`. Go to RB.
- **RB:** `mem_addr` = `b_ptr`. Latch `opa` ← `mem_rdata`. Go to WB.
- **WB:**
  - `mem_addr` = `b_ptr`, `mem_we` = 1.
  - `mem_wdata` = `mem_rdata` − `opa`, WIDTH bits, wrapping.
  - Register `pc_sel` ← `mem_wdata[WIDTH-1]`.
  - Go to UPD.
- **UPD:** pc ← `pc_next`. Go to FA, or to HALT (see Configuration).
- **HALT:** hold all registers. Leave only on `rst`.

Arithmetic:
- Operands are two's complement. Negative means MSB = 1.
- A zero result is not negative.
- Overflow is ignored; only the wrapped MSB counts.

PC arithmetic:
- pc+1, pc+2 and pc+3 wrap modulo 2^WIDTH.
- Example with WIDTH = 8, pc = 0xFE: fetch addresses are 0xFE, 0xFF, 0x00; `pc_plus3` = 0x01.

Other rules:
- A and B may be equal. The result is then 0, with no branch.
- B may point into the instruction words (self-modifying code is legal). The write lands in WB and is seen by the next fetch.
- `start` is ignored outside IDLE.

## Timing
- Every instruction takes exactly 7 cycles (FA through UPD). The PC updates on the UPD clock edge.
- `pc_sel` is registered: valid from UPD onward, stable through the next instruction until its WB edge.
- `pc_next` is sampled only in UPD. The mux must be combinational.
- `mem_we` is high for exactly one cycle per instruction, in WB.
- Reset values, applied on the next edge with `rst` = 1:
  - state = IDLE.
  - pc, `a_ptr`, `b_ptr`, `opa`, `br_target`, `pc_sel` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0.
  - `busy` = 0, `halted` = 0.
- Reset mid-instruction, including in WB, aborts without a further write: `mem_we` = 0 from the reset edge. Any write already committed in WB stands.
- `rst` takes priority over `start` when both are high.

## Configuration
- `SUBNEG_HALT_EN` defined:
  - In UPD, if `pc_sel` = 1 and `br_target` = {WIDTH{1'b1}}, go to HALT instead of FA.
  - The pc still loads `pc_next` (0xFF for WIDTH = 8).
  - `halted` = 1 and `busy` = 0.
- `SUBNEG_HALT_EN` undefined:
  - HALT is unreachable and `halted` is tied to 0.
  - A branch to all-ones executes normally, fetching at 0xFF, 0x00, 0x01.

## Test plan
- **Non-negative result:** mem[0..2] = {10, 11, 20}, mem[10] = 3, mem[11] = 5, pulse `start` → mem[11] = 2, `pc_sel` = 0, pc = 3 after 7 cycles, one `mem_we` pulse at addr 11.
- **Negative result:** as above but mem[10] = 7 → mem[11] = 0xFE, `pc_sel` = 1, pc = 20.
- **Zero and overflow:** A = B = 11, mem[11] = 0x40 → mem[11] = 0, pc = 3. Separately, mem[B] = 0x80, mem[A] = 0x01 → result 0x7F, no branch.
- **PC wrap:** pc preloaded to 0xFE via an earlier branch → fetch addresses 0xFE, 0xFF, 0x00, `pc_plus3` = 0x01.
- **Halt** (with `SUBNEG_HALT_EN`): taken branch with C = 0xFF → `halted` = 1, `busy` = 0, no further `mem_we`, `start` ignored. Without the macro: fetch resumes at 0xFF.
- **Reset mid-op:** assert `rst` during RB → next cycle state IDLE, pc = 0, `mem_we` = 0, memory unchanged. A following `start` re-executes from pc = 0.
